// File: rtl/owt_mcst_tx_ctrl.sv
// LV-side one-wire transmitter: sends a Manchester-coded sync/CMD/DATA/CRC8 frame,
// then waits for the receive path's frame acknowledge or a response timeout.
module owt_mcst_tx_ctrl #(
   parameter int HALF_CYC     = 16,
   parameter int SYNC_BIT_NUM = 12,
   parameter int CMD_BIT_NUM  = 8,
   parameter int DATA_BIT_NUM = 8,
   parameter int CRC_BIT_NUM  = 8,
   parameter int RSP_TMO_CYC  = 4096,
   parameter int TMO_CNT_W    = 13
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_owt_tx_req,
   input  logic [CMD_BIT_NUM-1:0]  i_owt_tx_cmd,
   input  logic [DATA_BIT_NUM-1:0] i_owt_tx_data,
   output logic                    o_owt_tx_rdy,
   output logic                    o_lv_hv_owt_tx,
   output logic [CMD_BIT_NUM-1:0]  o_owt_tx_cmd_lock,
   output logic                    o_owt_tx_done,
   input  logic                    i_owt_rx_ack,
   output logic                    o_owt_tx_rsp_ok,
   output logic                    o_owt_tx_tmo
);

   localparam int HALF_W   = (HALF_CYC > 2) ? $clog2(HALF_CYC) : 1;
   localparam int MAX_A    = (SYNC_BIT_NUM > CMD_BIT_NUM) ? SYNC_BIT_NUM : CMD_BIT_NUM;
   localparam int MAX_B    = (DATA_BIT_NUM > CRC_BIT_NUM) ? DATA_BIT_NUM : CRC_BIT_NUM;
   localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_BITS = (MAX_C > 4) ? MAX_C : 4;
   localparam int BIT_W    = $clog2(MAX_BITS);

   localparam logic [HALF_W-1:0]    HALF_LAST = HALF_W'(HALF_CYC - 1);
   localparam logic [BIT_W-1:0]     SYNC_LAST = BIT_W'(SYNC_BIT_NUM - 1);
   localparam logic [BIT_W-1:0]     CMD_LAST  = BIT_W'(CMD_BIT_NUM - 1);
   localparam logic [BIT_W-1:0]     DATA_LAST = BIT_W'(DATA_BIT_NUM - 1);
   localparam logic [BIT_W-1:0]     CRC_LAST  = BIT_W'(CRC_BIT_NUM - 1);
   localparam logic [BIT_W-1:0]     RAW_LAST  = BIT_W'(3);
   localparam logic [TMO_CNT_W-1:0] TMO_LAST  = TMO_CNT_W'(RSP_TMO_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC_HEAD,
      ST_SYNC_TAIL,
      ST_CMD,
      ST_DATA,
      ST_CRC,
      ST_END_TAIL,
      ST_WAIT_RSP
   } state_t;

   state_t                  state_q, state_d;
   logic [HALF_W-1:0]       half_cnt_q, half_cnt_d;
   logic                    half_flag_q, half_flag_d;
   logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [CMD_BIT_NUM-1:0]  cmd_lock_q, cmd_lock_d;
   logic [CMD_BIT_NUM-1:0]  cmd_sh_q, cmd_sh_d;
   logic [DATA_BIT_NUM-1:0] data_sh_q, data_sh_d;
   logic [7:0]              crc_q, crc_d;
   logic [TMO_CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic                    line_q, line_d;
   logic                    rdy_q, rdy_d;
   logic                    done_q, done_d;
   logic                    rsp_ok_q, rsp_ok_d;
   logic                    tmo_q, tmo_d;

   logic       unit_end;
   logic       cur_bit;
   logic [7:0] crc_fold;

   assign unit_end = (half_cnt_q == HALF_LAST);
   assign cur_bit  = (state_q == ST_CMD) ? cmd_sh_q[CMD_BIT_NUM-1] : data_sh_q[DATA_BIT_NUM-1];
   // Serial CRC8 (poly 0x07) step for the payload bit that is just finishing.
   assign crc_fold = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ cur_bit) ? 8'h07 : 8'h00);

   always_comb begin
      state_d     = state_q;
      half_cnt_d  = half_cnt_q;
      half_flag_d = half_flag_q;
      bit_cnt_d   = bit_cnt_q;
      cmd_lock_d  = cmd_lock_q;
      cmd_sh_d    = cmd_sh_q;
      data_sh_d   = data_sh_q;
      crc_d       = crc_q;
      tmo_cnt_d   = tmo_cnt_q;
      done_d      = 1'b0;
      rsp_ok_d    = 1'b0;
      tmo_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_owt_tx_req) begin
               cmd_lock_d  = i_owt_tx_cmd;
               cmd_sh_d    = i_owt_tx_cmd;
               data_sh_d   = i_owt_tx_data;
               crc_d       = 8'h00;
               half_cnt_d  = '0;
               half_flag_d = 1'b0;
               bit_cnt_d   = '0;
               state_d     = ST_SYNC_HEAD;
            end
         end
         ST_WAIT_RSP: begin
            if (i_owt_rx_ack) begin
               rsp_ok_d = 1'b1;
               state_d  = ST_IDLE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               tmo_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
            end
         end
         default: begin
            if (!unit_end) begin
               half_cnt_d = half_cnt_q + HALF_W'(1);
            end else begin
               half_cnt_d  = '0;
               half_flag_d = ~half_flag_q;
               case (state_q)
                  ST_SYNC_HEAD: begin
                     if (half_flag_q) begin
                        if (bit_cnt_q == SYNC_LAST) begin
                           bit_cnt_d = '0;
                           state_d   = ST_SYNC_TAIL;
                        end else begin
                           bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                     end
                  end
                  ST_SYNC_TAIL: begin
                     if (bit_cnt_q == RAW_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_CMD;
                     end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                     end
                  end
                  ST_CMD: begin
                     if (half_flag_q) begin
                        crc_d    = crc_fold;
                        cmd_sh_d = {cmd_sh_q[CMD_BIT_NUM-2:0], 1'b0};
                        if (bit_cnt_q == CMD_LAST) begin
                           bit_cnt_d = '0;
                           state_d   = ST_DATA;
                        end else begin
                           bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                     end
                  end
                  ST_DATA: begin
                     if (half_flag_q) begin
                        crc_d     = crc_fold;
                        data_sh_d = {data_sh_q[DATA_BIT_NUM-2:0], 1'b0};
                        if (bit_cnt_q == DATA_LAST) begin
                           bit_cnt_d = '0;
                           state_d   = ST_CRC;
                        end else begin
                           bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                     end
                  end
                  ST_CRC: begin
                     // The CRC is final by now, so it is shifted out in place.
                     if (half_flag_q) begin
                        crc_d = {crc_q[6:0], 1'b0};
                        if (bit_cnt_q == CRC_LAST) begin
                           bit_cnt_d = '0;
                           state_d   = ST_END_TAIL;
                        end else begin
                           bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                     end
                  end
                  default: begin
                     if (bit_cnt_q == RAW_LAST) begin
                        bit_cnt_d = '0;
                        tmo_cnt_d = '0;
                        done_d    = 1'b1;
                        state_d   = ST_WAIT_RSP;
                     end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                     end
                  end
               endcase
            end
         end
      endcase
   end

   // Line level for the unit that starts next cycle; Manchester halves are the bit then its inverse.
   always_comb begin
      line_d = 1'b0;
      case (state_d)
         ST_SYNC_HEAD: line_d = half_flag_d;
         ST_SYNC_TAIL: line_d = ~bit_cnt_d[1];
         ST_CMD:       line_d = cmd_sh_d[CMD_BIT_NUM-1] ^ half_flag_d;
         ST_DATA:      line_d = data_sh_d[DATA_BIT_NUM-1] ^ half_flag_d;
         ST_CRC:       line_d = crc_d[7] ^ half_flag_d;
         ST_END_TAIL:  line_d = ~bit_cnt_d[1];
         default:      line_d = 1'b0;
      endcase
      rdy_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         half_cnt_q  <= '0;
         half_flag_q <= 1'b0;
         bit_cnt_q   <= '0;
         cmd_lock_q  <= '0;
         cmd_sh_q    <= '0;
         data_sh_q   <= '0;
         crc_q       <= '0;
         tmo_cnt_q   <= '0;
         line_q      <= 1'b0;
         rdy_q       <= 1'b1;
         done_q      <= 1'b0;
         rsp_ok_q    <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         half_cnt_q  <= half_cnt_d;
         half_flag_q <= half_flag_d;
         bit_cnt_q   <= bit_cnt_d;
         cmd_lock_q  <= cmd_lock_d;
         cmd_sh_q    <= cmd_sh_d;
         data_sh_q   <= data_sh_d;
         crc_q       <= crc_d;
         tmo_cnt_q   <= tmo_cnt_d;
         line_q      <= line_d;
         rdy_q       <= rdy_d;
         done_q      <= done_d;
         rsp_ok_q    <= rsp_ok_d;
         tmo_q       <= tmo_d;
      end
   end

   assign o_owt_tx_rdy      = rdy_q;
   assign o_lv_hv_owt_tx    = line_q;
   assign o_owt_tx_cmd_lock = cmd_lock_q;
   assign o_owt_tx_done     = done_q;
   assign o_owt_tx_rsp_ok   = rsp_ok_q;
   assign o_owt_tx_tmo      = tmo_q;

endmodule

// File: tb/tb_owt_mcst_tx_ctrl.sv
// Directed + randomized bench for owt_mcst_tx_ctrl; the expected line pattern is
// rebuilt from the frame format and a long-division CRC8.
module tb_owt_mcst_tx_ctrl;

   localparam int H     = 4;
   localparam int SYNC  = 12;
   localparam int NB    = 8;
   localparam int TMO   = 16;
   localparam int UNITS = 2*SYNC + 4 + 2*(3*NB) + 4;
   localparam int CRC_U = 2*SYNC + 4 + 4*NB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req = 1'b0;
   logic       ack = 1'b0;
   logic [7:0] cmd_in = '0;
   logic [7:0] data_in = '0;
   logic       rdy, line, done, rsp_ok, tmo;
   logic [7:0] cmd_lock;

   int   n_checks = 0;
   int   n_pass = 0;
   logic exp_q[$];
   logic obs_u [UNITS];
   logic [7:0] crc_obs;

   owt_mcst_tx_ctrl #(
      .HALF_CYC(H), .SYNC_BIT_NUM(SYNC), .CMD_BIT_NUM(NB), .DATA_BIT_NUM(NB),
      .CRC_BIT_NUM(8), .RSP_TMO_CYC(TMO), .TMO_CNT_W(13)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_owt_tx_req(req), .i_owt_tx_cmd(cmd_in),
      .i_owt_tx_data(data_in), .o_owt_tx_rdy(rdy), .o_lv_hv_owt_tx(line),
      .o_owt_tx_cmd_lock(cmd_lock), .o_owt_tx_done(done), .i_owt_rx_ack(ack),
      .o_owt_tx_rsp_ok(rsp_ok), .o_owt_tx_tmo(tmo)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1.
   function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
      logic [23:0] v;
      v = {c, d, 8'h00};
      for (int i = 23; i >= 8; i--)
         if (v[i]) v = v ^ (24'h107 << (i - 8));
      return v[7:0];
   endfunction

   task automatic build_units(input logic [7:0] c, input logic [7:0] d);
      logic [23:0] payload;
      payload = {c, d, crc_ref(c, d)};
      exp_q.delete();
      for (int i = 0; i < SYNC; i++) begin
         exp_q.push_back(1'b0);
         exp_q.push_back(1'b1);
      end
      exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
      for (int i = 23; i >= 0; i--) begin
         exp_q.push_back(payload[i]);
         exp_q.push_back(~payload[i]);
      end
      exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
   endtask

   // Leaves the caller #1 into the cycle where done should be high (unless aborted).
   task automatic run_frame(input logic [7:0] c, input logic [7:0] d, input bit hold,
                            input int ack_at, input int abort_at);
      int budget;
      budget = 0;
      while (rdy !== 1'b1 && budget < 5000) begin
         @(posedge clk); #1;
         budget++;
      end
      if (rdy !== 1'b1) check("rdy_wait", 32'(rdy), 32'd1);
      build_units(c, d);
      req = 1'b1; cmd_in = c; data_in = d;
      @(posedge clk); #1;
      if (!hold) req = 1'b0;
      check("busy_rdy", 32'(rdy), 32'd0);
      check("rsp_ok_pulse", 32'(rsp_ok), 32'd0);
      check("tmo_pulse", 32'(tmo), 32'd0);
      check("cmd_lock_accept", 32'(cmd_lock), 32'(c));
      for (int i = 0; i < UNITS*H; i++) begin
         if (i == abort_at) begin
            #3 rst_n = 1'b0;
            #1;
            check("rst_line", 32'(line), 32'd0);
            check("rst_rdy", 32'(rdy), 32'd1);
            check("rst_cmd_lock", 32'(cmd_lock), 32'd0);
            req = 1'b0; ack = 1'b0;
            @(posedge clk); @(posedge clk); #3;
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("rst_release_rdy", 32'(rdy), 32'd1);
            check("rst_release_line", 32'(line), 32'd0);
            return;
         end
         if (i % H == 0) obs_u[i/H] = line;
         check($sformatf("line[%0d]", i), 32'(line), 32'(exp_q[i/H]));
         if (i == UNITS*H - 1) check("done_early", 32'(done), 32'd0);
         if (hold) begin
            cmd_in = 8'($urandom);
            data_in = 8'($urandom);
         end
         ack = (i == ack_at);
         @(posedge clk); #1;
      end
      ack = 1'b0; req = 1'b0;
      check("done", 32'(done), 32'd1);
      check("line_end", 32'(line), 32'd0);
      check("cmd_lock_end", 32'(cmd_lock), 32'(c));
      for (int k = 0; k < 8; k++) crc_obs[7-k] = obs_u[CRC_U + 2*k];
      $display("frame cmd=0x%02h data=0x%02h crc_on_line=0x%02h", c, d, crc_obs);
   endtask

   // Starts in the done cycle; ack_delay<0 or >=TMO means no ack inside the window.
   task automatic rsp_phase(input int ack_delay);
      bit ok_exp;
      int end_k;
      ok_exp = (ack_delay >= 0 && ack_delay <= TMO - 1);
      end_k  = ok_exp ? ack_delay : TMO - 1;
      for (int k = 0; k <= end_k; k++) begin
         ack = (k == ack_delay);
         @(posedge clk); #1;
         ack = 1'b0;
         if (k == 0) check("done_width", 32'(done), 32'd0);
         if (k < end_k) begin
            check("wait_rsp_ok", 32'(rsp_ok), 32'd0);
            check("wait_tmo", 32'(tmo), 32'd0);
            check("wait_rdy", 32'(rdy), 32'd0);
         end else begin
            check("end_rsp_ok", 32'(rsp_ok), 32'(ok_exp));
            check("end_tmo", 32'(tmo), 32'(!ok_exp));
            check("end_rdy", 32'(rdy), 32'd1);
         end
      end
      $display("response ack_delay=%0d -> rsp_ok=%0b tmo=%0b", ack_delay, rsp_ok, tmo);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_rdy", 32'(rdy), 32'd1);
      check("reset_line", 32'(line), 32'd0);
      check("reset_cmd_lock", 32'(cmd_lock), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_rsp_ok", 32'(rsp_ok), 32'd0);
      check("reset_tmo", 32'(tmo), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      run_frame(8'h80, 8'h00, 1'b0, -1, -1);
      check("crc_80_00", 32'(crc_obs), 32'hB6);
      rsp_phase(10);
      // Back-to-back: request in the very cycle rdy returns.
      run_frame(8'h01, 8'h00, 1'b0, -1, -1);
      check("crc_01_00", 32'(crc_obs), 32'h15);
      rsp_phase(-1);

      run_frame(8'h00, 8'h00, 1'b0, -1, -1);
      check("crc_00_00", 32'(crc_obs), 32'h00);
      rsp_phase(TMO - 1);

      run_frame(8'hA5, 8'h3C, 1'b1, (2*SYNC + 4)*H + 5, -1);
      rsp_phase(3);

      run_frame(8'hC3, 8'h5A, 1'b0, -1, (2*SYNC + 4 + 2*NB)*H + 6);
      run_frame(8'h7E, 8'h81, 1'b0, -1, -1);
      rsp_phase(0);

      for (int n = 0; n < 6; n++) begin
         logic [7:0] rc, rd;
         int dly;
         rc  = 8'($urandom);
         rd  = 8'($urandom);
         dly = int'($urandom_range(0, 20));
         run_frame(rc, rd, 1'b0, -1, -1);
         rsp_phase(dly);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
